// File: rtl/prio_req_latch_amisha.sv
// Request-capture stage ahead of a 4-input priority encoder: sync, edge-detect,
// sticky pending bits, valid/ack hand-off of the encoder code, overrun counting.
// Define PRIO_REQ_SYNC_EN to add a metastability flop ahead of the sample stage.
module prio_req_latch_amisha #(
    parameter int OVR_W = 8
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic [4:1]       req_in_amisha,
    input  logic [2:0]       y_amisha,
    input  logic             ack_amisha,
    input  logic             ovr_clr_amisha,
    output logic [4:1]       r_amisha,
    output logic             valid_amisha,
    output logic [2:0]       code_amisha,
    output logic [OVR_W-1:0] ovr_cnt_amisha
);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    state_t           state;
    logic [4:1]       s;
    logic [4:1]       s_d;
    logic [4:1]       edge_v;
    logic [4:1]       pend;
    logic [4:1]       clr;
    logic [4:1]       ovr_bits;
    logic [2:0]       n_ovr;
    logic [OVR_W+2:0] ovr_sum;

    // NOTE: every flop here, synchroniser included, is cleared by the async reset
    // and written with non-blocking assignments so all stages see pre-edge values.
`ifdef PRIO_REQ_SYNC_EN
    logic [4:1] meta;

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            meta <= '0;
            s    <= '0;
        end else begin
            meta <= req_in_amisha;
            s    <= meta;
        end
    end
`else
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) s <= '0;
        else               s <= req_in_amisha;
    end
`endif

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) s_d <= '0;
        else               s_d <= s;
    end

    assign edge_v = s & ~s_d;

    // NOTE: default assignment first so no path leaves clr unassigned (no latch).
    always_comb begin
        clr = '0;
        if (state == GRANT && ack_amisha) begin
            case (code_amisha)
                3'd1:    clr[1] = 1'b1;
                3'd2:    clr[2] = 1'b1;
                3'd3:    clr[3] = 1'b1;
                3'd4:    clr[4] = 1'b1;
                default: ;
            endcase
        end
    end

    // A new edge on a bit that is still pending (and not being serviced) is lost.
    assign ovr_bits = edge_v & pend & ~clr;

    always_comb begin
        n_ovr = '0;
        for (int i = 1; i <= 4; i++) n_ovr = n_ovr + {2'b00, ovr_bits[i]};
    end

    assign ovr_sum = {3'b000, ovr_cnt_amisha} + {{OVR_W{1'b0}}, n_ovr};

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            ovr_cnt_amisha <= '0;
        end else if (ovr_clr_amisha) begin
            ovr_cnt_amisha <= '0;
        end else if (ovr_sum > {3'b000, OVR_MAX}) begin
            ovr_cnt_amisha <= OVR_MAX;
        end else begin
            ovr_cnt_amisha <= ovr_sum[OVR_W-1:0];
        end
    end

    // Set is OR-ed in after the clear, so a same-cycle edge keeps the bit pending.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) pend <= '0;
        else               pend <= (pend & ~clr) | edge_v;
    end

    assign r_amisha = pend;

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state        <= IDLE;
            valid_amisha <= 1'b0;
            code_amisha  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_amisha <= 1'b0;
                    if (pend != '0) state <= ARB;
                end
                ARB: begin
                    // Encoder output only trusted when it names a real bit.
                    if (y_amisha >= 3'd1 && y_amisha <= 3'd4) begin
                        code_amisha  <= y_amisha;
                        valid_amisha <= 1'b1;
                        state        <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (ack_amisha) begin
                        valid_amisha <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    valid_amisha <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_req_latch_amisha.sv
// Bench for prio_req_latch_amisha: event-level model plus directed scenarios,
// with the downstream priority encoder modelled around the DUT.
module tb_prio_req_latch_amisha;

    localparam int OVR_W = 2;
`ifdef PRIO_REQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic             clk;
    logic             rst_n;
    logic [4:1]       req;
    logic [2:0]       y;
    logic             ack;
    logic             ovr_clr;
    logic             enc_fault;
    logic [4:1]       r;
    logic             valid;
    logic [2:0]       code;
    logic [OVR_W-1:0] ovr_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    prio_req_latch_amisha #(.OVR_W(OVR_W)) dut (
        .clk_amisha     (clk),
        .rst_n_amisha   (rst_n),
        .req_in_amisha  (req),
        .y_amisha       (y),
        .ack_amisha     (ack),
        .ovr_clr_amisha (ovr_clr),
        .r_amisha       (r),
        .valid_amisha   (valid),
        .code_amisha    (code),
        .ovr_cnt_amisha (ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int top_bit(input logic [4:1] v);
        for (int i = 4; i >= 1; i--) if (v[i]) return i;
        return 0;
    endfunction

    // Downstream encoder, with an optional stuck-at-zero fault.
    assign y = enc_fault ? 3'd0 : 3'(top_bit(r));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:1] hist [0:2];   // hist[k] = request lines sampled k+1 edges ago
    logic [4:1] m_pend;
    int         m_phase;      // 0 idle, 1 arbitrating, 2 code offered
    int         m_code;
    int         m_ovr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hist[k] = '0;
            m_pend  = '0;
            m_phase = 0;
            m_code  = 0;
            m_ovr   = 0;
        end else begin
            logic [4:1] ev;
            logic [4:1] np;
            int ci;
            int lost;
            int yv;
            ev   = hist[L-1] & ~hist[L];
            ci   = (m_phase == 2 && ack) ? m_code : 0;
            lost = 0;
            np   = m_pend;
            for (int i = 1; i <= 4; i++) begin
                if (ev[i]) begin
                    if (m_pend[i] && ci != i) lost++;
                    np[i] = 1'b1;
                end else if (ci == i) begin
                    np[i] = 1'b0;
                end
            end
            if (ovr_clr) m_ovr = 0;
            else         m_ovr = (m_ovr + lost > (1 << OVR_W) - 1) ? (1 << OVR_W) - 1 : m_ovr + lost;
            case (m_phase)
                0: if (m_pend != '0) m_phase = 1;
                1: begin
                    yv = enc_fault ? 0 : top_bit(m_pend);
                    if (yv != 0) begin
                        m_code  = yv;
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                end
                default: if (ack) m_phase = 0;
            endcase
            m_pend = np;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = req;
        end
    end

    always @(negedge clk) begin
        check("r",     r,       m_pend);
        check("valid", valid,   m_phase == 2);
        check("code",  code,    m_code);
        check("ovr",   ovr_cnt, m_ovr);
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:1] bits);
        req = bits;
        tick;
        req = '0;
        tick;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!valid && n < 20) begin
            tick;
            n++;
        end
        check({name, "_timeout"}, valid, 1);
    endtask

    initial begin
        int         vcyc[$];
        logic [2:0] codes[$];
        logic [4:1] rs[$];
        logic [2:0] exp_code [0:2];
        logic [4:1] exp_r    [0:2];
        exp_code = '{3'd4, 3'd2, 3'd1};
        exp_r    = '{4'b1011, 4'b0011, 4'b0001};

        rst_n = 1'b1; req = '0; ack = 1'b0; ovr_clr = 1'b0; enc_fault = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick;
        check("reset_valid", valid, 0);
        check("reset_r", r, 0);
        rst_n = 1'b1;
        repeat (2) tick;

        // Single request on bit 3.
        req = 4'b0100;
        tick;
        req = '0;
        repeat (L) tick;
        check("single_r", r, 4'b0100);
        repeat (2) tick;
        check("single_valid", valid, 1);
        check("single_code", code, 3'b011);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        check("single_ack_r", r, 0);
        check("single_ack_valid", valid, 0);
        repeat (3) tick;

        // Three simultaneous requests, ack held high throughout.
        ack = 1'b1;
        pulse(4'b1011);
        for (int c = 0; c < 30; c++) begin
            tick;
            if (valid) begin
                vcyc.push_back(c);
                codes.push_back(code);
                rs.push_back(r);
            end
        end
        ack = 1'b0;
        check("multi_count", codes.size(), 3);
        if (codes.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check("multi_code", codes[k], exp_code[k]);
                check("multi_r", rs[k], exp_r[k]);
            end
            check("multi_gap1", vcyc[1] - vcyc[0], 3);
            check("multi_gap2", vcyc[2] - vcyc[1], 3);
        end
        check("multi_done_r", r, 0);

        // New edge on bit 4 coinciding with the ack that clears it.
        pulse(4'b1000);
        wait_valid("coll_first");
        req = 4'b1000;
        tick;
        req = '0;
        repeat (L - 1) tick;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        check("coll_r", r, 4'b1000);
        check("coll_valid", valid, 0);
        check("coll_ovr", ovr_cnt, 0);
        wait_valid("coll_second");
        check("coll_code", code, 3'b100);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        repeat (3) tick;

        // Overrun counting, clear, then saturation.
        pulse(4'b0001);
        pulse(4'b0001);
        repeat (3) tick;
        check("ovr_one", ovr_cnt, 1);
        pulse(4'b0001);
        pulse(4'b0001);
        repeat (3) tick;
        check("ovr_three", ovr_cnt, 3);
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        check("ovr_clear", ovr_cnt, 0);
        repeat (5) pulse(4'b0001);
        repeat (3) tick;
        check("ovr_sat", ovr_cnt, 3);
        check("ovr_valid", valid, 1);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        repeat (2) tick;

        // Stray ack while idle changes nothing.
        ack = 1'b1;
        tick;
        ack = 1'b0;
        repeat (2) tick;
        check("stray_r", r, 0);
        check("stray_valid", valid, 0);
        check("stray_code", code, 3'b001);

        // Encoder returning 0 in arbitration: no grant, code untouched.
        enc_fault = 1'b1;
        pulse(4'b0100);
        repeat (6) tick;
        check("fault_valid", valid, 0);
        check("fault_code", code, 3'b001);
        check("fault_r", r, 4'b0100);
        enc_fault = 1'b0;
        wait_valid("fault_recover");
        check("fault_recover_code", code, 3'b011);

        // Asynchronous reset in the middle of a grant.
        rst_n = 1'b0;
        #1;
        check("rst_async_r", r, 0);
        check("rst_async_valid", valid, 0);
        check("rst_async_code", code, 0);
        check("rst_async_ovr", ovr_cnt, 0);
        #5 rst_n = 1'b1;
        repeat (6) tick;
        check("rst_after_valid", valid, 0);
        check("rst_after_r", r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
